// File: rtl/peak_valley_detect.sv
// Windowed peak/valley tracker for the channel-0 ADS2 vibration path.
// Emits one peak/valley pair per WIN_LEN samples and flags stalled streams.
module peak_valley_detect #(
  parameter logic [15:0] WIN_LEN     = 16'd256,
  parameter logic [15:0] SETTLE_CNT  = 16'd16,
  parameter logic [23:0] TIMEOUT_CYC = 24'd1000000,
  parameter logic        SIGNED_IN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Ch0_Data_ads2,
  input  logic        Ch0_Data_en_ads2,
  output logic [15:0] Ch0_PData_ads2,
  output logic        Ch0_PData_en_ads2,
  output logic [15:0] Ch0_VData_ads2,
  output logic        Ch0_VData_en_ads2,
  output logic        Ch0_stale_ads2
);

  typedef enum logic [1:0] {
    SETTLE,
    FIRST,
    TRACK
  } state_t;

  localparam state_t RST_ST =
    (SETTLE_CNT == 16'd0) ? FIRST : SETTLE;

  state_t      state;
  logic [15:0] max_q;
  logic [15:0] min_q;
  logic [15:0] win_cnt;
  logic [15:0] settle_cnt;
  logic [23:0] idle_cnt;

  logic [15:0] x;
  logic [15:0] hi_nxt;
  logic [15:0] lo_nxt;
  logic [15:0] win_nxt;
  logic [15:0] set_nxt;
  logic [23:0] idle_nxt;
  logic        idle_hit;

  assign x = SIGNED_IN ?
    {~Ch0_Data_ads2[15], Ch0_Data_ads2[14:0]} :
    Ch0_Data_ads2;

  always_comb begin
    hi_nxt   = (x > max_q) ? x : max_q;
    lo_nxt   = (x < min_q) ? x : min_q;
    win_nxt  = win_cnt + 16'd1;
    set_nxt  = settle_cnt + 16'd1;
    idle_nxt = (idle_cnt == TIMEOUT_CYC) ?
      idle_cnt : idle_cnt + 24'd1;
    idle_hit = (TIMEOUT_CYC != 24'd0) &&
      (idle_nxt == TIMEOUT_CYC);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= RST_ST;
      max_q             <= '0;
      min_q             <= '0;
      win_cnt           <= '0;
      settle_cnt        <= '0;
      idle_cnt          <= '0;
      Ch0_PData_ads2    <= '0;
      Ch0_VData_ads2    <= '0;
      Ch0_PData_en_ads2 <= 1'b0;
      Ch0_VData_en_ads2 <= 1'b0;
      Ch0_stale_ads2    <= 1'b0;
    end else begin
      Ch0_PData_en_ads2 <= 1'b0;
      Ch0_VData_en_ads2 <= 1'b0;
      if (Ch0_Data_en_ads2) begin
        idle_cnt       <= '0;
        Ch0_stale_ads2 <= 1'b0;
        unique case (state)
          SETTLE: begin
            settle_cnt <= set_nxt;
            if (set_nxt == SETTLE_CNT)
              state <= FIRST;
          end
          FIRST: begin
            max_q   <= x;
            min_q   <= x;
            win_cnt <= 16'd1;
            if (WIN_LEN == 16'd1) begin
              Ch0_PData_ads2    <= x;
              Ch0_VData_ads2    <= x;
              Ch0_PData_en_ads2 <= 1'b1;
              Ch0_VData_en_ads2 <= 1'b1;
            end else begin
              state <= TRACK;
            end
          end
          TRACK: begin
            max_q   <= hi_nxt;
            min_q   <= lo_nxt;
            win_cnt <= win_nxt;
            if (win_nxt == WIN_LEN) begin
              Ch0_PData_ads2    <= hi_nxt;
              Ch0_VData_ads2    <= lo_nxt;
              Ch0_PData_en_ads2 <= 1'b1;
              Ch0_VData_en_ads2 <= 1'b1;
              state             <= FIRST;
            end
          end
          default: state <= FIRST;
        endcase
      end else if (TIMEOUT_CYC != 24'd0) begin
        idle_cnt <= idle_nxt;
        // Stale stream: drop the partial window, keep P/V.
        if (idle_hit) begin
          Ch0_stale_ads2 <= 1'b1;
          state          <= FIRST;
        end
      end
    end
  end

endmodule

// File: tb/tb_peak_valley_detect.sv
// Scoreboard bench for peak_valley_detect across four
// parameter sets driven one scenario at a time.
module tb_peak_valley_detect;

  typedef struct {
    int          id;
    logic [15:0] p;
    logic [15:0] v;
  } exp_t;

  logic        clk;
  logic        rst_v [4];
  logic [15:0] d     [4];
  logic        en    [4];
  logic [15:0] p     [4];
  logic        pe    [4];
  logic [15:0] v     [4];
  logic        ve    [4];
  logic        st    [4];

  exp_t sbq [$];
  int   n_vec;
  int   n_bad;

  peak_valley_detect #(
    .WIN_LEN(16'd4), .SETTLE_CNT(16'd0),
    .TIMEOUT_CYC(24'd100), .SIGNED_IN(1'b0)
  ) u_a (
    .clk(clk), .rst(rst_v[0]),
    .Ch0_Data_ads2(d[0]), .Ch0_Data_en_ads2(en[0]),
    .Ch0_PData_ads2(p[0]), .Ch0_PData_en_ads2(pe[0]),
    .Ch0_VData_ads2(v[0]), .Ch0_VData_en_ads2(ve[0]),
    .Ch0_stale_ads2(st[0])
  );

  peak_valley_detect #(
    .WIN_LEN(16'd2), .SETTLE_CNT(16'd0),
    .TIMEOUT_CYC(24'd0), .SIGNED_IN(1'b1)
  ) u_b (
    .clk(clk), .rst(rst_v[1]),
    .Ch0_Data_ads2(d[1]), .Ch0_Data_en_ads2(en[1]),
    .Ch0_PData_ads2(p[1]), .Ch0_PData_en_ads2(pe[1]),
    .Ch0_VData_ads2(v[1]), .Ch0_VData_en_ads2(ve[1]),
    .Ch0_stale_ads2(st[1])
  );

  peak_valley_detect #(
    .WIN_LEN(16'd2), .SETTLE_CNT(16'd3),
    .TIMEOUT_CYC(24'd0), .SIGNED_IN(1'b0)
  ) u_c (
    .clk(clk), .rst(rst_v[2]),
    .Ch0_Data_ads2(d[2]), .Ch0_Data_en_ads2(en[2]),
    .Ch0_PData_ads2(p[2]), .Ch0_PData_en_ads2(pe[2]),
    .Ch0_VData_ads2(v[2]), .Ch0_VData_en_ads2(ve[2]),
    .Ch0_stale_ads2(st[2])
  );

  peak_valley_detect #(
    .WIN_LEN(16'd4), .SETTLE_CNT(16'd3),
    .TIMEOUT_CYC(24'd0), .SIGNED_IN(1'b0)
  ) u_d (
    .clk(clk), .rst(rst_v[3]),
    .Ch0_Data_ads2(d[3]), .Ch0_Data_en_ads2(en[3]),
    .Ch0_PData_ads2(p[3]), .Ch0_PData_en_ads2(pe[3]),
    .Ch0_VData_ads2(v[3]), .Ch0_VData_en_ads2(ve[3]),
    .Ch0_stale_ads2(st[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (pe[i] === 1'b1 || ve[i] === 1'b1) begin
        exp_t e;
        n_vec++;
        if (pe[i] !== ve[i]) begin
          n_bad++;
          $display("FAIL strobe_pair u%0d: pe=%b ve=%b want equal",
                   i, pe[i], ve[i]);
        end
        if (sbq.size() == 0) begin
          n_bad++;
          $display("FAIL spurious u%0d: P=%h V=%h want no strobe",
                   i, p[i], v[i]);
        end else begin
          e = sbq.pop_front();
          if (e.id != i || p[i] !== e.p || v[i] !== e.v) begin
            n_bad++;
            $display("FAIL window u%0d: P=%h V=%h want u%0d P=%h V=%h",
                     i, p[i], v[i], e.id, e.p, e.v);
          end
        end
      end
    end
  end

  task automatic push(int id, logic [15:0] ep, logic [15:0] ev);
    exp_t e;
    e.id = id;
    e.p  = ep;
    e.v  = ev;
    sbq.push_back(e);
  endtask

  task automatic samp(int i, logic [15:0] x);
    d[i]  = x;
    en[i] = 1'b1;
    @(posedge clk);
    #1;
    en[i] = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 4; i++) begin
      rst_v[i] = 1'b0;
      en[i]    = 1'b0;
      d[i]     = 16'h0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      logic [34:0] obs;
      obs = {p[i], v[i], pe[i], ve[i], st[i]};
      n_vec++;
      if (obs !== 35'h0) begin
        n_bad++;
        $display("FAIL reset u%0d: got %h want 0", i, obs);
      end
    end
    for (int i = 0; i < 4; i++) rst_v[i] = 1'b1;
    idle(1);
  endtask

  task automatic test_basic;
    push(0, 16'h9000, 16'h0500);
    samp(0, 16'h1000); idle(2);
    samp(0, 16'h9000); idle(2);
    samp(0, 16'h0500); idle(2);
    samp(0, 16'h7000);
    @(negedge clk);
    n_vec++;
    if (pe[0] !== 1'b1 || ve[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_latency: pe=%b ve=%b want 1 1",
               pe[0], ve[0]);
    end
    @(negedge clk);
    n_vec++;
    if (pe[0] !== 1'b0 || ve[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_width: pe=%b ve=%b want 0 0",
               pe[0], ve[0]);
    end
    idle(2);
  endtask

  task automatic test_signed;
    push(1, 16'hFFFF, 16'h0000);
    samp(1, 16'h7FFF);
    samp(1, 16'h8000);
    idle(3);
  endtask

  task automatic test_settle;
    push(2, 16'h3000, 16'h2000);
    for (int k = 0; k < 3; k++) samp(2, 16'hFFFF);
    samp(2, 16'h2000);
    samp(2, 16'h3000);
    idle(3);
  endtask

  task automatic test_back_to_back;
    push(0, 16'd4, 16'd1);
    push(0, 16'd8, 16'd5);
    for (int k = 1; k <= 8; k++) begin
      logic want;
      want  = (k == 4) || (k == 8);
      d[0]  = 16'(k);
      en[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (pe[0] !== want) begin
        n_bad++;
        $display("FAIL b2b_cycle%0d: pe=%b want %b",
                 k + 1, pe[0], want);
      end
    end
    en[0] = 1'b0;
    idle(2);
  endtask

  task automatic test_ties;
    push(0, 16'h1234, 16'h1234);
    for (int k = 0; k < 4; k++) samp(0, 16'h1234);
    idle(4);
    @(negedge clk);
    n_vec++;
    if (p[0] !== 16'h1234 || v[0] !== 16'h1234) begin
      n_bad++;
      $display("FAIL hold: P=%h V=%h want 1234 1234", p[0], v[0]);
    end
  endtask

  task automatic test_timeout;
    samp(0, 16'h0100);
    samp(0, 16'h0200);
    repeat (99) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (st[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL stale_early: stale=%b want 0", st[0]);
    end
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (st[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL stale_set: stale=%b want 1", st[0]);
    end
    push(0, 16'h0600, 16'h0300);
    samp(0, 16'h0300);
    n_vec++;
    if (st[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL stale_clear: stale=%b want 0", st[0]);
    end
    samp(0, 16'h0400);
    samp(0, 16'h0500);
    samp(0, 16'h0600);
    idle(3);
  endtask

  task automatic test_reset_mid;
    logic [34:0] obs;
    push(3, 16'h0A00, 16'h0700);
    for (int k = 0; k < 3; k++) samp(3, 16'h5555);
    samp(3, 16'h0700);
    samp(3, 16'h0800);
    samp(3, 16'h0900);
    samp(3, 16'h0A00);
    idle(2);
    samp(3, 16'h0010);
    samp(3, 16'h0020);
    rst_v[3] = 1'b0;
    samp(3, 16'hFFFF);
    rst_v[3] = 1'b1;
    obs = {p[3], v[3], pe[3], ve[3], st[3]};
    n_vec++;
    if (obs !== 35'h0) begin
      n_bad++;
      $display("FAIL mid_reset: got %h want 0", obs);
    end
    push(3, 16'h0400, 16'h0100);
    for (int k = 0; k < 3; k++) samp(3, 16'hF000);
    samp(3, 16'h0100);
    samp(3, 16'h0200);
    samp(3, 16'h0300);
    n_vec++;
    if (pe[3] !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_early: pe=%b want 0", pe[3]);
    end
    samp(3, 16'h0400);
    n_vec++;
    if (pe[3] !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_strobe: pe=%b want 1", pe[3]);
    end
    idle(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t want finish", $time);
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    test_reset;
    test_basic;
    test_signed;
    test_settle;
    test_back_to_back;
    test_ties;
    test_timeout;
    test_reset_mid;
    idle(4);
    n_vec++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d pending want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
